// File: rtl/swipt_drive_nco.sv
// Phase-accumulator NCO that turns a frequency word (Hz) into complementary half-bridge gate drives
// with dead time; new frequencies are range-checked and only take effect at a period boundary.
module swipt_drive_nco #(
   parameter int unsigned FREQ_MULT  = 43980,
   parameter int unsigned FREQ_SHIFT = 10,
   parameter int unsigned DEAD_CYC   = 20,
   parameter logic [19:0] F_MIN      = 20'h88B8,
   parameter logic [19:0] F_MAX      = 20'hAFC8,
   parameter logic [19:0] F_DEFAULT  = 20'h88B8
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        drive_en,
   input  logic        freq_valid,
   input  logic [19:0] freq_in,
   output logic        freq_ack,
   output logic        freq_err,
   output logic [19:0] cur_freq,
   output logic        gate_hs,
   output logic        gate_ls,
   output logic        cycle_strobe,
   output logic        running
);

   localparam int DW = $clog2(DEAD_CYC + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

   state_t        state, nxt_state;
   logic [35:0]   prod;
   logic [31:0]   inc;
   logic [31:0]   acc;
   logic [32:0]   acc_sum;
   logic [DW-1:0] dead;
   logic [19:0]   pend_freq;
   logic          pend_valid;
   logic          active, start, wrap, apply, in_range, phase_flip;

   assign prod    = 36'(cur_freq) * 36'(FREQ_MULT);
   assign inc     = 32'(prod >> FREQ_SHIFT);
   assign acc_sum = {1'b0, acc} + {1'b0, inc};

   // A period boundary is the clock on which the accumulator carries out of bit 31.
   assign wrap       = active & acc_sum[32];
   assign phase_flip = active & (acc_sum[31] != acc[31]);

   // Frequency handshake: freq_valid is a single-cycle offer with no back-pressure; each offer is
   // answered one clock later by exactly one of freq_ack (latched as pending) or freq_err (dropped).
   assign in_range = (freq_in >= F_MIN) && (freq_in <= F_MAX);
   assign apply    = pend_valid && ((state == IDLE) || wrap);

   always_ff @(posedge clk) begin
      if (!nrst) state <= IDLE;
      else       state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (drive_en) nxt_state = RUN;
         RUN:     if (!drive_en) nxt_state = STOP;
         STOP:    if (drive_en) nxt_state = RUN;
                  else if (wrap) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      active  = (state == RUN) || (state == STOP);
      start   = (state == IDLE) && drive_en;
      running = active;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         acc          <= '0;
         dead         <= '0;
         cur_freq     <= F_DEFAULT;
         pend_freq    <= '0;
         pend_valid   <= 1'b0;
         freq_ack     <= 1'b0;
         freq_err     <= 1'b0;
         cycle_strobe <= 1'b0;
         gate_hs      <= 1'b0;
         gate_ls      <= 1'b0;
      end else begin
         freq_ack     <= freq_valid & in_range;
         freq_err     <= freq_valid & ~in_range;
         cycle_strobe <= start | wrap;

         // Apply uses the old pending value; a same-clock offer becomes the next pending one.
         if (apply) begin
            cur_freq   <= pend_freq;
            pend_valid <= 1'b0;
         end
         if (freq_valid && in_range) begin
            pend_freq  <= freq_in;
            pend_valid <= 1'b1;
         end

         if (start) begin
            acc  <= '0;
            dead <= DW'(DEAD_CYC);
         end else if (active) begin
            acc <= acc_sum[31:0];
            if (phase_flip)      dead <= DW'(DEAD_CYC);
            else if (dead != '0) dead <= dead - DW'(1);
         end else begin
            acc  <= '0;
            dead <= '0;
         end

         // Both gates derive from one phase bit, so they can never be high together.
         gate_hs <= active && (nxt_state != IDLE) && (dead == '0) && !acc[31];
         gate_ls <= active && (nxt_state != IDLE) && (dead == '0) &&  acc[31];
      end
   end

endmodule

// File: tb/tb_swipt_drive_nco.sv
// Self-checking bench for swipt_drive_nco: handshake vector table, randomized offers against a
// frequency model, and period/half-period/dead-time monitors computed from the NCO arithmetic.
module tb_swipt_drive_nco;

   localparam int          DEAD_CYC  = 20;
   localparam int          F_LO      = 35000;
   localparam int          F_HI      = 45000;
   localparam logic [19:0] F_RESET   = 20'd35000;

   logic        clk = 1'b0;
   logic        nrst, drive_en, freq_valid;
   logic [19:0] freq_in;
   logic        freq_ack, freq_err, gate_hs, gate_ls, cycle_strobe, running;
   logic [19:0] cur_freq;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   swipt_drive_nco dut (
      .clk          (clk),
      .nrst         (nrst),
      .drive_en     (drive_en),
      .freq_valid   (freq_valid),
      .freq_in      (freq_in),
      .freq_ack     (freq_ack),
      .freq_err     (freq_err),
      .cur_freq     (cur_freq),
      .gate_hs      (gate_hs),
      .gate_ls      (gate_ls),
      .cycle_strobe (cycle_strobe),
      .running      (running)
   );

   // Frequency model: what cur_freq must be, and what is waiting for the next boundary.
   logic [19:0] m_cur = F_RESET;
   logic [19:0] m_pend = '0;
   logic        m_pend_v = 1'b0;
   logic [1:0]  exp_q[$];

   function automatic longint inc_of(input longint f);
      return (f * 43980) >> 10;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
      n_assert++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   task automatic offer(input logic [19:0] f);
      logic       ok;
      logic [1:0] e;
      ok = (int'(f) >= F_LO) && (int'(f) <= F_HI);
      exp_q.push_back({ok, !ok});
      if (ok) begin
         m_pend   = f;
         m_pend_v = 1'b1;
      end
      freq_in    = f;
      freq_valid = 1'b1;
      tick();
      freq_valid = 1'b0;
      e = exp_q.pop_front();
      chk("freq_ack", freq_ack, e[1]);
      chk("freq_err", freq_err, e[0]);
   endtask

   task automatic idle_settle();
      tick();
      if (m_pend_v) begin
         m_cur    = m_pend;
         m_pend_v = 1'b0;
      end
      chk("idle_cur_freq", cur_freq, m_cur);
   endtask

   task automatic wait_strobe(input int budget, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!cycle_strobe && cnt < budget);
      if (!cycle_strobe) begin
         n_assert++;
         n_fail++;
         $display("FAIL strobe_timeout: no cycle_strobe within %0d clocks", budget);
      end else if (m_pend_v) begin
         m_cur    = m_pend;
         m_pend_v = 1'b0;
      end
   endtask

   // Continuous monitors: overlap, dead-time gaps, half-period and period lengths.
   logic        mon_en = 1'b0;
   int          overlap_cnt = 0;
   int          hs_len = 0, ls_len = 0, gap_len = 0, per_len = 0;
   logic        gap_open = 1'b0, prev_on = 1'b0, per_open = 1'b0;
   logic [19:0] period_freq = F_RESET, last_period_freq = F_RESET;

   always @(negedge clk) begin
      longint h, p;
      logic [19:0] f;
      if (mon_en) begin
         if (gate_hs && gate_ls) overlap_cnt++;
         per_len++;

         if (gate_hs) hs_len++;
         else if (hs_len != 0) begin
            if (running || cycle_strobe) begin
               h = 64'h8000_0000 / inc_of(longint'(period_freq));
               chk_rng("hs_half_period", hs_len, h - DEAD_CYC - 1, h - DEAD_CYC + 1);
            end
            hs_len = 0;
         end

         if (gate_ls) ls_len++;
         else if (ls_len != 0) begin
            if (running || cycle_strobe) begin
               f = cycle_strobe ? period_freq : last_period_freq;
               h = 64'h8000_0000 / inc_of(longint'(f));
               chk_rng("ls_half_period", ls_len, h - DEAD_CYC - 1, h - DEAD_CYC + 1);
            end
            ls_len = 0;
         end

         if (running && (gate_hs || gate_ls)) begin
            if (gap_open) chk("dead_time", gap_len, DEAD_CYC);
            gap_open = 1'b0;
         end else if (running) begin
            if (prev_on) begin
               gap_open = 1'b1;
               gap_len  = 0;
            end
            if (gap_open) gap_len++;
         end else begin
            gap_open = 1'b0;
         end
         prev_on = running && (gate_hs || gate_ls);

         if (cycle_strobe) begin
            if (per_open) begin
               p = 64'h1_0000_0000 / inc_of(longint'(period_freq));
               chk_rng("strobe_period", per_len, p - 1, p + 1);
            end
            last_period_freq = period_freq;
            period_freq      = cur_freq;
            per_len          = 0;
            per_open         = running;
         end else if (!running) begin
            per_open = 1'b0;
         end
      end
   end

   typedef struct {
      logic [19:0] freq;
      logic        exp_ack;
      logic        exp_err;
      logic [19:0] exp_cur;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int n, cnt, lowcnt;
      longint p;
      logic [19:0] rf;

      vecs[0] = '{20'd34999,   1'b0, 1'b1, 20'd35000};
      vecs[1] = '{20'd45001,   1'b0, 1'b1, 20'd35000};
      vecs[2] = '{20'd45000,   1'b1, 1'b0, 20'd45000};
      vecs[3] = '{20'd35000,   1'b1, 1'b0, 20'd35000};
      vecs[4] = '{20'd0,       1'b0, 1'b1, 20'd35000};
      vecs[5] = '{20'hFFFFF,   1'b0, 1'b1, 20'd35000};
      vecs[6] = '{20'd40000,   1'b1, 1'b0, 20'd40000};
      vecs[7] = '{20'd45000,   1'b1, 1'b0, 20'd45000};
      vecs[8] = '{20'd35001,   1'b1, 1'b0, 20'd35001};

      // Reset behaviour
      nrst = 1'b0; drive_en = 1'b0; freq_valid = 1'b0; freq_in = '0;
      repeat (2) tick();
      chk("rst_gate_hs", gate_hs, 0);
      chk("rst_gate_ls", gate_ls, 0);
      chk("rst_freq_ack", freq_ack, 0);
      chk("rst_freq_err", freq_err, 0);
      chk("rst_strobe", cycle_strobe, 0);
      chk("rst_running", running, 0);
      chk("rst_cur_freq", cur_freq, F_RESET);
      nrst = 1'b1;
      mon_en = 1'b1;
      repeat (4) tick();
      chk("idle_gate_hs", gate_hs, 0);
      chk("idle_gate_ls", gate_ls, 0);
      chk("idle_running", running, 0);

      // Handshake table in IDLE
      for (int i = 0; i < 9; i++) begin
         freq_in = vecs[i].freq;
         freq_valid = 1'b1;
         tick();
         freq_valid = 1'b0;
         chk("tbl_ack", freq_ack, vecs[i].exp_ack);
         chk("tbl_err", freq_err, vecs[i].exp_err);
         tick();
         chk("tbl_cur_freq", cur_freq, vecs[i].exp_cur);
         m_cur = vecs[i].exp_cur;
      end

      // Randomized offers in IDLE against the model
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 5))
            0:       rf = 20'(F_LO);
            1:       rf = 20'(F_HI);
            default: rf = 20'($urandom_range(33000, 47000));
         endcase
         offer(rf);
         idle_settle();
      end

      // Run at 40 kHz
      offer(20'd40000);
      idle_settle();
      drive_en = 1'b1;
      tick();
      chk("start_strobe", cycle_strobe, 1);
      chk("start_running", running, 1);
      n = 0;
      while (!gate_hs && n < 100) begin
         tick();
         n++;
      end
      chk("start_latency", n, DEAD_CYC + 1);
      wait_strobe(4000, cnt);
      chk_rng("first_period_40k", n + cnt, 2499, 2501);
      wait_strobe(4000, cnt);
      chk_rng("period_40k", cnt, 2499, 2501);

      // Glitch-free change: takes effect only at the next strobe
      offer(20'd35000);
      chk("pending_not_applied", cur_freq, m_cur);
      wait_strobe(4000, cnt);
      chk("applied_at_strobe", cur_freq, m_cur);
      repeat (600) tick();
      offer(20'd45000);
      chk("midperiod_hold", cur_freq, m_cur);
      wait_strobe(4000, cnt);
      chk("midperiod_applied", cur_freq, m_cur);

      // Last offer wins
      repeat (300) tick();
      offer(20'd40000);
      offer(20'd35000);
      wait_strobe(4000, cnt);
      chk("last_wins", cur_freq, m_cur);

      // Out-of-range while running leaves the frequency alone
      repeat (200) tick();
      offer(20'd34999);
      offer(20'd45001);
      chk("err_hold", cur_freq, m_cur);
      wait_strobe(4000, cnt);
      chk("err_no_apply", cur_freq, m_cur);
      offer(20'd45000);
      wait_strobe(4000, cnt);
      chk("max_applied", cur_freq, m_cur);

      // Stop runs to the wrap, then idles
      repeat (500) tick();
      drive_en = 1'b0;
      n = 0;
      while (running && n < 4000) begin
         tick();
         n++;
      end
      chk("stop_idle", running, 0);
      chk("stop_at_wrap", cycle_strobe, 1);
      chk("stop_gate_hs", gate_hs, 0);
      chk("stop_gate_ls", gate_ls, 0);
      tick();
      chk("stopped_gate_hs", gate_hs, 0);
      chk("stopped_gate_ls", gate_ls, 0);

      // Restart, then drop and re-raise drive_en before the wrap
      drive_en = 1'b1;
      tick();
      chk("restart_strobe", cycle_strobe, 1);
      p = 64'h1_0000_0000 / inc_of(longint'(m_cur));
      wait_strobe(4000, cnt);
      chk_rng("restart_period", cnt, p - 1, p + 1);
      repeat (700) tick();
      drive_en = 1'b0;
      lowcnt = 0;
      repeat (50) begin
         tick();
         if (!running) lowcnt++;
      end
      drive_en = 1'b1;
      wait_strobe(4000, cnt);
      chk("reraise_no_gap", lowcnt, 0);
      chk_rng("reraise_period", 750 + cnt, p - 1, p + 1);

      // Reset mid-period while the high side is on
      n = 0;
      while (!gate_hs && n < 4000) begin
         tick();
         n++;
      end
      chk("hs_before_reset", gate_hs, 1);
      repeat (5) tick();
      nrst = 1'b0;
      drive_en = 1'b0;
      tick();
      m_cur = F_RESET;
      m_pend_v = 1'b0;
      chk("midrst_gate_hs", gate_hs, 0);
      chk("midrst_gate_ls", gate_ls, 0);
      chk("midrst_running", running, 0);
      chk("midrst_strobe", cycle_strobe, 0);
      chk("midrst_cur_freq", cur_freq, m_cur);
      nrst = 1'b1;
      repeat (3) tick();
      chk("post_rst_gate_hs", gate_hs, 0);
      chk("post_rst_gate_ls", gate_ls, 0);

      chk("gate_overlap_cycles", overlap_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
